// File: rtl/matriz_pkg.sv
// Shared constants, scan states and pixel helpers for the 5x7 LED matrix scanner.
package matriz_pkg;

    localparam int unsigned NUM_COLS = 5;
    localparam int unsigned NUM_ROWS = 7;
    localparam int unsigned NUM_PIX  = 35;
    localparam int unsigned IDX_W    = $clog2(NUM_PIX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_BLANK
    } estado_t;

    function automatic logic [IDX_W-1:0] pix_idx(input int unsigned r, input int unsigned c);
        return IDX_W'(r * NUM_COLS + c);
    endfunction

    // Active-low row bus for one column, taken straight from the active-low pixel vector.
    function automatic logic [NUM_ROWS-1:0] linhas_coluna(input logic [NUM_PIX-1:0] snap,
                                                          input logic [2:0]         c);
        logic [NUM_ROWS-1:0] l;
        l = '1;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            l[r] = snap[pix_idx(r, 32'(c))];
        end
        return l;
    endfunction

endpackage

// File: rtl/varredura_matriz_leds_if.sv
// Pixel input / matrix drive bundle of the LED matrix scanner.
interface varredura_matriz_leds_if;
    import matriz_pkg::*;

    logic                en;
    logic [NUM_PIX-1:0]  N_m_at;
    logic [NUM_COLS-1:0] colunas;
    logic [NUM_ROWS-1:0] linhas;
    logic                frame_fim;

    modport master (output en, N_m_at, input colunas, linhas, frame_fim);
    modport slave  (input en, N_m_at, output colunas, linhas, frame_fim);

endinterface

// File: rtl/divisor_tick.sv
// Modulo counter with synchronous clear and a runtime terminal value; tick on terminal count.
module divisor_tick #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == term_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/varredura_matriz_leds.sv
// Column-multiplexed 5x7 LED matrix scanner with per-frame snapshot of the pixel vector.
// Optional inter-column dead time enabled by defining VARREDURA_BLANK_EN.
module varredura_matriz_leds
    import matriz_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    varredura_matriz_leds_if.slave bus
);

    if (DIV < 2) begin : g_chk_div
        $error("DIV must be >= 2");
    end
    if (BLANK < 1) begin : g_chk_blank
        $error("BLANK must be >= 1");
    end

`ifdef VARREDURA_BLANK_EN
    localparam int unsigned PW = ($clog2(BLANK) > $clog2(DIV)) ? $clog2(BLANK) : $clog2(DIV);
`else
    localparam int unsigned PW = $clog2(DIV);
`endif

    estado_t             estado_q, estado_d;
    logic [2:0]          col_q, col_d;
    logic [NUM_PIX-1:0]  snap_q, snap_d;
    logic [NUM_COLS-1:0] colunas_q, colunas_d;
    logic [NUM_ROWS-1:0] linhas_q, linhas_d;
    logic                frame_fim_q, frame_fim_d;

    logic                tick;
    logic [PW-1:0]       term;
    logic                wrap;
    logic [2:0]          col_nxt;
    logic [NUM_PIX-1:0]  snap_nxt;

`ifdef VARREDURA_BLANK_EN
    assign term = (estado_q == ST_BLANK) ? PW'(BLANK - 1) : PW'(DIV - 1);
`else
    assign term = PW'(DIV - 1);
`endif

    divisor_tick #(.W(PW)) u_dwell (
        .clk    (clk),
        .rst    (reset),
        .clr_i  ((estado_q == ST_IDLE) || !bus.en),
        .en_i   (estado_q != ST_IDLE),
        .term_i (term),
        .tick_o (tick)
    );

    // Column advance; the snapshot refreshes only when column 4 wraps to 0.
    assign wrap     = (col_q == 3'd4);
    assign col_nxt  = wrap ? 3'd0 : col_q + 3'd1;
    assign snap_nxt = wrap ? bus.N_m_at : snap_q;

    always_comb begin
        estado_d    = estado_q;
        col_d       = col_q;
        snap_d      = snap_q;
        colunas_d   = colunas_q;
        linhas_d    = linhas_q;
        frame_fim_d = 1'b0;
        if (!bus.en) begin
            estado_d  = ST_IDLE;
            col_d     = '0;
            colunas_d = '0;
            linhas_d  = '1;
        end else begin
            case (estado_q)
                ST_IDLE: begin
                    estado_d  = ST_SCAN;
                    snap_d    = bus.N_m_at;
                    col_d     = '0;
                    colunas_d = 5'b00001;
                    linhas_d  = linhas_coluna(bus.N_m_at, 3'd0);
                end
                ST_SCAN: begin
                    if (tick) begin
`ifdef VARREDURA_BLANK_EN
                        estado_d  = ST_BLANK;
                        colunas_d = '0;
                        linhas_d  = '1;
`else
                        col_d       = col_nxt;
                        snap_d      = snap_nxt;
                        frame_fim_d = wrap;
                        colunas_d   = 5'b00001 << col_nxt;
                        linhas_d    = linhas_coluna(snap_nxt, col_nxt);
`endif
                    end
                end
`ifdef VARREDURA_BLANK_EN
                ST_BLANK: begin
                    if (tick) begin
                        estado_d    = ST_SCAN;
                        col_d       = col_nxt;
                        snap_d      = snap_nxt;
                        frame_fim_d = wrap;
                        colunas_d   = 5'b00001 << col_nxt;
                        linhas_d    = linhas_coluna(snap_nxt, col_nxt);
                    end
                end
`endif
                default: begin
                    estado_d  = ST_IDLE;
                    col_d     = '0;
                    colunas_d = '0;
                    linhas_d  = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q    <= ST_IDLE;
            col_q       <= '0;
            snap_q      <= '1;
            colunas_q   <= '0;
            linhas_q    <= '1;
            frame_fim_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            col_q       <= col_d;
            snap_q      <= snap_d;
            colunas_q   <= colunas_d;
            linhas_q    <= linhas_d;
            frame_fim_q <= frame_fim_d;
        end
    end

    assign bus.colunas   = colunas_q;
    assign bus.linhas    = linhas_q;
    assign bus.frame_fim = frame_fim_q;

endmodule

// File: tb/tb_varredura_matriz_leds.sv
// Scoreboard bench for the LED matrix scanner (DIV=4, BLANK=2); follows VARREDURA_BLANK_EN.
module tb_varredura_matriz_leds;
    import matriz_pkg::*;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 2;

    typedef struct {
        logic [4:0] col;
        logic [6:0] lin;
        logic       ff;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [NUM_PIX-1:0] pat, pat2;

    always #5 clk = ~clk;

    varredura_matriz_leds_if bus ();

    varredura_matriz_leds #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Monitor: outputs are valid every cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.colunas !== e.col || bus.linhas !== e.lin || bus.frame_fim !== e.ff) begin
                errors++;
                $display("FAIL %s: got colunas=%b linhas=%b frame_fim=%b, expected colunas=%b linhas=%b frame_fim=%b",
                         e.nm, bus.colunas, bus.linhas, bus.frame_fim, e.col, e.lin, e.ff);
            end
        end
    end

    task automatic step(input logic [4:0] c, input logic [6:0] l, input logic f, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.col = c;
        e.lin = l;
        e.ff  = f;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic run_col(input int unsigned c, input logic [6:0] l, input logic f, input string nm);
        logic [4:0] oh;
        oh = 5'(1 << c);
        for (int unsigned k = 0; k < DIV; k++) begin
            step(oh, l, (k == 0) ? f : 1'b0, nm);
        end
    endtask

    task automatic gap();
`ifdef VARREDURA_BLANK_EN
        for (int unsigned k = 0; k < BLANK; k++) begin
            step(5'b00000, 7'h7F, 1'b0, "blank");
        end
`endif
    endtask

    initial begin
        exp_t e;
        reset      = 1'b1;
        bus.en     = 1'b0;
        bus.N_m_at = '1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(5'b00000, 7'h7F, 1'b0, "idle_after_reset");

        pat        = {{34{1'b1}}, 1'b0};
        bus.N_m_at = pat;
        bus.en     = 1'b1;

        // frame 1: start from IDLE, no frame_fim
        run_col(0, 7'h7E, 1'b0, "f1_c0"); gap();
        for (int unsigned c = 1; c < 5; c++) begin
            run_col(c, 7'h7F, 1'b0, "f1_cx"); gap();
        end

        // frame 2: pattern change during column 2 must not show yet
        run_col(0, 7'h7E, 1'b1, "f2_c0_wrap"); gap();
        run_col(1, 7'h7F, 1'b0, "f2_c1"); gap();
        step(5'b00100, 7'h7F, 1'b0, "f2_c2");
        pat2       = pat & ~(35'd1 << 34);
        bus.N_m_at = pat2;
        for (int unsigned k = 1; k < DIV; k++) step(5'b00100, 7'h7F, 1'b0, "hold_c2");
        gap();
        run_col(3, 7'h7F, 1'b0, "hold_c3"); gap();
        run_col(4, 7'h7F, 1'b0, "hold_c4_old"); gap();

        // frame 3: fresh snapshot, row 6 of column 4 lit
        run_col(0, 7'h7E, 1'b1, "f3_c0_wrap"); gap();
        for (int unsigned c = 1; c < 4; c++) begin
            run_col(c, 7'h7F, 1'b0, "f3_cx"); gap();
        end
        run_col(4, 7'h3F, 1'b0, "f3_c4_new"); gap();

        // frame 4: enable drop during column 3
        run_col(0, 7'h7E, 1'b1, "f4_c0_wrap"); gap();
        run_col(1, 7'h7F, 1'b0, "f4_c1"); gap();
        run_col(2, 7'h7F, 1'b0, "f4_c2"); gap();
        step(5'b01000, 7'h7F, 1'b0, "f4_c3");
        bus.en = 1'b0;
        step(5'b00000, 7'h7F, 1'b0, "en_drop_dark");
        step(5'b00000, 7'h7F, 1'b0, "idle_dark");
        bus.en = 1'b1;
        run_col(0, 7'h7E, 1'b0, "resume_c0"); gap();
        run_col(1, 7'h7F, 1'b0, "resume_c1"); gap();

        // asynchronous reset mid column 2, checked before the next edge
        step(5'b00100, 7'h7F, 1'b0, "pre_rst_c2");
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        e.col = 5'b00000;
        e.lin = 7'h7F;
        e.ff  = 1'b0;
        e.nm  = "async_reset";
        sb.push_back(e);
        step(5'b00000, 7'h7F, 1'b0, "reset_wins_over_en");
        reset = 1'b0;
        run_col(0, 7'h7E, 1'b0, "restart_c0"); gap();
        run_col(1, 7'h7F, 1'b0, "restart_c1");
        bus.en = 1'b0;
        step(5'b00000, 7'h7F, 1'b0, "final_dark");

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
